fetch_unit: RTL

Instruction fetch stage directly upstream of the word-addressed `mem` block. It holds the program counter and drives `mem`'s address and read lines. It captures each returned word with its PC in a small prefetch FIFO and presents them to decode over a valid/ready handshake. It also handles control-flow redirects and, optionally, rejects misaligned fetch targets.

---
 rtl/fetch_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, prefetch FIFO toward decode, redirect handling.
// Defining FETCH_ALIGN_CHECK_EN adds a FAULT state that latches on misaligned redirect targets.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] memAddr,
    output logic        memRead,
    output logic        memWrite,
    input  logic [31:0] memOut,
    input  logic        redirect,
    input  logic [31:0] target,
    output logic        insValid,
    input  logic        insReady,
    output logic [31:0] ins,
    output logic [31:0] insPc,
    output logic        fault
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
        $error("fetch_unit: DEPTH must be a power of 2 and at least 2");
    end
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("fetch_unit: RESET_PC must be word aligned");
    end

    typedef enum logic [0:0] {StRun, StFault} state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   fifo_ins [DEPTH];
    logic [31:0]   fifo_pc  [DEPTH];

    logic          pop;
    logic          fetch;
    logic          target_aligned;
    logic [31:0]   target_load;

    assign target_aligned = (target[1:0] == 2'b00);

`ifdef FETCH_ALIGN_CHECK_EN
    assign target_load = target;
`else
    // Without the check, misaligned targets are silently rounded down to a word boundary.
    assign target_load = {target[31:2], 2'b00};
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
`ifdef FETCH_ALIGN_CHECK_EN
                if (redirect && !target_aligned) begin
                    state_d = StFault;
                end
`endif
            end
            StFault: begin
                if (redirect && target_aligned) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // Outputs and handshake decode.
    always_comb begin
        insValid = (count_q != '0);
        pop      = insValid && insReady;
        // A pop frees a slot in the same cycle, so a full FIFO can still fetch.
        fetch    = !rst && (state_q == StRun) && !redirect && ((count_q < FULL) || pop);
        memRead  = fetch;
        memAddr  = pc_q;
        memWrite = 1'b0;
        ins      = insValid ? fifo_ins[rd_ptr_q] : 32'h0;
        insPc    = insValid ? fifo_pc[rd_ptr_q] : 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
        fault    = (state_q == StFault);
`else
        fault    = 1'b0;
`endif
    end

    // PC and FIFO pointer next-state.
    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect) begin
            // Flush wins over any pop attempted in the same cycle.
            pc_d     = target_load;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (fetch) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                pc_d     = pc_q + 32'd4;
            end
            if (fetch && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !fetch) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Storage needs no reset: outputs are gated by insValid.
    always_ff @(posedge clk) begin
        if (fetch) begin
            fifo_ins[wr_ptr_q] <= memOut;
            fifo_pc[wr_ptr_q]  <= pc_q;
        end
    end

endmodule
